// File: rtl/channel_seq_if.sv
// AXI-Stream link used by channel_seq: the PS-side source stream and the stream to the
// channel waveform mux both use this bundle.
interface channel_seq_if #(
  parameter int DATA_W = 256
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  // master drives data/valid; slave drives ready
  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/channel_seq.sv
// Channel waveform sequencer: loads a waveform from the PS stream into the channel mux,
// then arms, waits for a trigger and plays it for the requested repetitions.
// Optional feature: define CHANNEL_SEQ_TIMEOUT_EN to add the LOAD stall timeout / ERROR state.
module channel_seq #(
  parameter int DATA_W  = 256,
  parameter int LEN_W   = 16,
  parameter int REP_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [LEN_W-1:0]   length,
  input  logic [REP_W-1:0]   reps,
  channel_seq_if.slave       s_axis,
  channel_seq_if.master      m_axis,
  input  logic               play_beat,
  input  logic               ext_trigger,
  output logic               select_out,
  output logic               trigger_out,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ARM   = 3'd2,
    PLAY  = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [REP_W-1:0]  reps_q, reps_d;
  logic [LEN_W-1:0]  word_q, word_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic [DATA_W-1:0] pass_data;
  logic              load_hs;
  logic              last_word;
  logic              last_rep;

  // Stream handshake: both directions are plain valid/ready. A beat transfers on a
  // rising edge where valid and ready are both high; valid never waits on ready. In LOAD
  // the PS stream is wired straight through to the mux with zero latency, otherwise
  // both valid toward the mux and ready toward the PS are held low.
  assign pass_data     = s_axis.tdata;
  assign m_axis.tdata  = pass_data;
  assign m_axis.tvalid = (state_q == LOAD) && s_axis.tvalid;
  assign s_axis.tready = (state_q == LOAD) && m_axis.tready;
  assign load_hs       = (state_q == LOAD) && s_axis.tvalid && m_axis.tready;

  assign last_word = (word_q == len_q - LEN_W'(1));
  assign last_rep  = (rep_q == reps_q - REP_W'(1));

  assign state       = state_q;
  assign busy        = (state_q == LOAD) || (state_q == ARM) || (state_q == PLAY);
  assign select_out  = (state_q == ARM) || (state_q == PLAY);
  assign trigger_out = (state_q == ARM) && ext_trigger && !abort;
  assign done        = (state_q == DONE);

`ifdef CHANNEL_SEQ_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  assign err = (state_q == ERROR);
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    reps_d  = reps_q;
    word_d  = word_q;
    rep_d   = rep_q;
`ifdef CHANNEL_SEQ_TIMEOUT_EN
    stall_d = stall_q;
`endif
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      word_d  = '0;
      rep_d   = '0;
`ifdef CHANNEL_SEQ_TIMEOUT_EN
      stall_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (length != '0) && (reps != '0)) begin
            len_d   = length;
            reps_d  = reps;
            word_d  = '0;
            rep_d   = '0;
            state_d = LOAD;
`ifdef CHANNEL_SEQ_TIMEOUT_EN
            stall_d = '0;
`endif
          end
        end
        LOAD: begin
          if (load_hs) begin
`ifdef CHANNEL_SEQ_TIMEOUT_EN
            stall_d = '0;
`endif
            if (last_word) begin
              word_d  = '0;
              state_d = ARM;
            end else begin
              word_d = word_q + LEN_W'(1);
            end
          end
`ifdef CHANNEL_SEQ_TIMEOUT_EN
          else if (stall_q == STALL_W'(TIMEOUT - 1)) begin
            stall_d = '0;
            state_d = ERROR;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
`endif
        end
        ARM: begin
          if (ext_trigger) state_d = PLAY;
        end
        PLAY: begin
          if (play_beat) begin
            if (last_word) begin
              word_d = '0;
              if (last_rep) begin
                rep_d   = '0;
                state_d = DONE;
              end else begin
                rep_d = rep_q + REP_W'(1);
              end
            end else begin
              word_d = word_q + LEN_W'(1);
            end
          end
        end
        DONE:    state_d = IDLE;
        // start only releases the error here; a fresh start is needed from IDLE
        ERROR:   if (start) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      reps_q  <= '0;
      word_q  <= '0;
      rep_q   <= '0;
`ifdef CHANNEL_SEQ_TIMEOUT_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      reps_q  <= reps_d;
      word_q  <= word_d;
      rep_q   <= rep_d;
`ifdef CHANNEL_SEQ_TIMEOUT_EN
      stall_q <= stall_d;
`endif
    end
  end

endmodule

// File: tb/tb_channel_seq.sv
// Directed bench for channel_seq: load, arm, play, abort, reset and stall scenarios.
module tb_channel_seq;

  localparam int DW = 32;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] length;
  logic [15:0] reps;
  logic        play_beat;
  logic        ext_trigger;
  logic        select_out;
  logic        trigger_out;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  state;

  channel_seq_if #(.DATA_W(DW)) s_if ();
  channel_seq_if #(.DATA_W(DW)) m_if ();

  channel_seq #(
    .DATA_W(DW), .LEN_W(16), .REP_W(16), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .length(length), .reps(reps),
    .s_axis(s_if), .m_axis(m_if),
    .play_beat(play_beat), .ext_trigger(ext_trigger),
    .select_out(select_out), .trigger_out(trigger_out),
    .busy(busy), .done(done), .err(err), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_asserts++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // drivers: every task starts and ends just after a falling edge
  task automatic pulse_start(input logic [15:0] l, input logic [15:0] r);
    length = l;
    reps   = r;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic load_words(input int n, input int stall_after, input int stall_cycles);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = DW'($urandom);
      s_if.tdata  = w;
      s_if.tvalid = 1'b1;
      if (i == stall_after) begin
        for (int s = 0; s < stall_cycles; s++) begin
          m_if.tready = 1'b0;
          #1;
          check("stall_state", state, 1);
          check("stall_s_tready", s_if.tready, 0);
          check("stall_m_tvalid", m_if.tvalid, 1);
          check("stall_m_tdata", m_if.tdata, w);
          @(negedge clk);
        end
      end
      m_if.tready = 1'b1;
      exp_q.push_back(w);
      #1;
      check("load_state", state, 1);
      check("load_s_tready", s_if.tready, 1);
      check("load_m_tvalid", m_if.tvalid, 1);
      check("load_m_tdata", m_if.tdata, exp_q.pop_front());
      @(negedge clk);
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic arm_trigger();
    ext_trigger = 1'b1;
    #1;
    check("arm_select", select_out, 1);
    check("arm_trigger_pulse", trigger_out, 1);
    @(negedge clk);
    #1;
    check("play_entered", state, 3);
    check("trigger_in_play", trigger_out, 0);
    ext_trigger = 1'b0;
    #1;
    check("trigger_low", trigger_out, 0);
  endtask

  task automatic play_beats(input int n);
    for (int i = 0; i < n; i++) begin
      play_beat = 1'b1;
      #1;
      check("beat_state", state, 3);
      check("beat_select", select_out, 1);
      check("beat_no_done", done, 0);
      @(negedge clk);
      play_beat = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; length = '0; reps = '0;
    play_beat = 1'b0; ext_trigger = 1'b1;
    s_if.tdata = '0; s_if.tvalid = 1'b1; m_if.tready = 1'b1;

    // reset state, with live inputs that must not leak through
    #1;
    check("rst_state", state, 0);
    check("rst_busy", busy, 0);
    check("rst_select", select_out, 0);
    check("rst_trigger", trigger_out, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_s_tready", s_if.tready, 0);
    @(negedge clk);
    @(negedge clk);
    ext_trigger = 1'b0; s_if.tvalid = 1'b0;
    rst = 1'b1;

    // length 4, reps 3; start accepted on the first edge after release
    pulse_start(16'd4, 16'd3);
    #1;
    check("t1_load", state, 1);
    check("t1_busy", busy, 1);
    check("t1_select_load", select_out, 0);
    load_words(4, -1, 0);
    #1;
    check("t1_arm", state, 2);
    check("t1_select_arm", select_out, 1);
    check("t1_arm_s_tready", s_if.tready, 0);
    check("t1_arm_trigger_idle", trigger_out, 0);
    pulse_start(16'd2, 16'd1);
    #1;
    check("t1_start_ignored", state, 2);
    arm_trigger();
    play_beats(11);
    #1;
    check("t1_before_last", state, 3);
    check("t1_no_done_early", done, 0);
    play_beats(1);
    #1;
    check("t1_done_state", state, 4);
    check("t1_done_pulse", done, 1);
    check("t1_done_busy", busy, 0);
    @(negedge clk);
    #1;
    check("t1_idle", state, 0);
    check("t1_done_once", done, 0);
    check("t1_select_idle", select_out, 0);

    // zero length / zero reps starts are ignored
    s_if.tvalid = 1'b1; m_if.tready = 1'b1;
    pulse_start(16'd0, 16'd5);
    #1;
    check("t2_len0_state", state, 0);
    check("t2_len0_busy", busy, 0);
    check("t2_len0_s_tready", s_if.tready, 0);
    pulse_start(16'd3, 16'd0);
    #1;
    check("t2_rep0_state", state, 0);
    check("t2_rep0_s_tready", s_if.tready, 0);
    s_if.tvalid = 1'b0;

    // length 8 with a 3-cycle downstream stall after 2 words
    pulse_start(16'd8, 16'd1);
    load_words(8, 2, 3);
    #1;
    check("t3_arm", state, 2);
    arm_trigger();
    play_beats(8);
    #1;
    check("t3_done", done, 1);
    @(negedge clk);

    // abort beats play_beat after 5 beats
    pulse_start(16'd4, 16'd3);
    load_words(4, -1, 0);
    arm_trigger();
    play_beats(5);
    abort = 1'b1; play_beat = 1'b1;
    @(negedge clk);
    abort = 1'b0; play_beat = 1'b0;
    #1;
    check("t4_idle", state, 0);
    check("t4_no_done", done, 0);
    check("t4_select", select_out, 0);
    check("t4_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("t4_no_late_done", done, 0);
    end

    // abort beats ext_trigger in ARM
    pulse_start(16'd2, 16'd1);
    load_words(2, -1, 0);
    abort = 1'b1; ext_trigger = 1'b1;
    #1;
    check("t5_trigger_masked", trigger_out, 0);
    @(negedge clk);
    abort = 1'b0; ext_trigger = 1'b0;
    #1;
    check("t5_idle", state, 0);

    // abort in LOAD
    pulse_start(16'd4, 16'd1);
    load_words(1, -1, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("t5_load_abort", state, 0);
    check("t5_load_abort_tready", s_if.tready, 0);

    // source never valid in LOAD
    pulse_start(16'd4, 16'd1);
    s_if.tvalid = 1'b0; m_if.tready = 1'b1;
`ifdef CHANNEL_SEQ_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      #1;
      check("t6_still_load", state, 1);
      check("t6_no_err", err, 0);
      @(negedge clk);
    end
    #1;
    check("t6_error", state, 5);
    check("t6_err", err, 1);
    check("t6_err_busy", busy, 0);
    check("t6_err_select", select_out, 0);
    @(negedge clk);
    #1;
    check("t6_err_sticky", err, 1);
    pulse_start(16'd4, 16'd1);
    #1;
    check("t6_exit_idle", state, 0);
    check("t6_err_clear", err, 0);
`else
    for (int i = 0; i < 40; i++) @(negedge clk);
    #1;
    check("t6_waits", state, 1);
    check("t6_err_tied", err, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("t6_abort_idle", state, 0);
`endif

    // asynchronous reset mid-LOAD
    pulse_start(16'd4, 16'd1);
    s_if.tvalid = 1'b1; m_if.tready = 1'b1;
    #3;
    check("t7_load_tvalid", m_if.tvalid, 1);
    rst = 1'b0;
    #1;
    check("t7_rst_tvalid", m_if.tvalid, 0);
    check("t7_rst_tready", s_if.tready, 0);
    @(negedge clk);
    rst = 1'b1; s_if.tvalid = 1'b0;

    // asynchronous reset mid-PLAY, then a normal short run
    pulse_start(16'd4, 16'd2);
    load_words(4, -1, 0);
    arm_trigger();
    play_beats(3);
    ext_trigger = 1'b1; s_if.tvalid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("t8_rst_state", state, 0);
    check("t8_rst_select", select_out, 0);
    check("t8_rst_busy", busy, 0);
    check("t8_rst_trigger", trigger_out, 0);
    check("t8_rst_done", done, 0);
    check("t8_rst_tvalid", m_if.tvalid, 0);
    check("t8_rst_tready", s_if.tready, 0);
    @(negedge clk);
    rst = 1'b1; ext_trigger = 1'b0; s_if.tvalid = 1'b0;
    #1;
    check("t8_no_done_after", done, 0);
    @(negedge clk);
    pulse_start(16'd2, 16'd1);
    load_words(2, -1, 0);
    #1;
    check("t8_arm", state, 2);
    arm_trigger();
    play_beats(2);
    #1;
    check("t8_done", done, 1);
    @(negedge clk);
    #1;
    check("t8_idle", state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/channel_seq.md
CHANNEL_SEQ -- requirements
Module: channel_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 256, AXI-Stream data width in bits.
REQ-002 SHALL have parameter LEN_W, default 16, width of waveform length and word counter.
REQ-003 SHALL have parameter REP_W, default 16, width of repetition count and repetition counter.
REQ-004 SHALL have parameter TIMEOUT, default 1024, load-stall limit in cycles (used only under REQ-031).
REQ-005 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset; asynchronous assert, active-low (0 = reset).
REQ-007 SHALL have ports start  in  1  one-cycle load/play request; abort  in  1  cancel request.
REQ-008 SHALL have ports length  in  LEN_W  waveform words; reps  in  REP_W  playback repetitions.
REQ-009 SHALL have ports s_axis_tdata  in  DATA_W, s_axis_tvalid  in  1, s_axis_tready  out  1 (PS source stream).
REQ-010 SHALL have ports m_axis_tdata  out  DATA_W, m_axis_tvalid  out  1, m_axis_tready  in  1 (to channel waveform mux).
REQ-011 SHALL have ports play_beat  in  1  one pulse per word sent to DAC; ext_trigger  in  1  playback trigger.
REQ-012 SHALL have ports select_out  out  1  mux select (0 = PS, 1 = loopback); trigger_out  out  1  playback trigger pulse.
REQ-013 SHALL have ports busy  out  1, done  out  1  one-cycle pulse, err  out  1  sticky error, state  out  3  encoded state.

Function
REQ-014 SHALL implement states IDLE=0, LOAD=1, ARM=2, PLAY=3, DONE=4, ERROR=5.
REQ-015 IDLE: start with length!=0 and reps!=0 SHALL latch length/reps, clear counters, go LOAD next cycle; start with length==0 or reps==0 SHALL be ignored.
REQ-016 LOAD: m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready, combinational, zero latency; outside LOAD m_axis_tvalid=0 and s_axis_tready=0.
REQ-017 LOAD: word counter SHALL increment on each m_axis handshake; handshake at count length-1 SHALL go ARM, counter cleared.
REQ-018 ARM: select_out=1; first cycle ext_trigger=1 SHALL go PLAY and pulse trigger_out for exactly that transition cycle.
REQ-019 PLAY: each play_beat SHALL advance word counter; at length-1 word counter wraps to 0 and rep counter increments.
REQ-020 PLAY: play_beat with word==length-1 and rep==reps-1 SHALL go DONE.
REQ-021 DONE: done=1 for one cycle, then IDLE; select_out SHALL return to 0 in IDLE.
REQ-022 busy SHALL be 1 in LOAD, ARM, PLAY; 0 otherwise.
REQ-023 start while busy SHALL be ignored; latched length/reps SHALL not change until next IDLE start.
REQ-024 abort in any state other than IDLE SHALL go IDLE next cycle, select_out=0, no done pulse; abort beats ext_trigger, play_beat and start in same cycle.
REQ-025 ERROR: select_out=0, busy=0; leaves to IDLE only on start (start then processed as in REQ-015 one cycle later) or abort; err clears on that exit.
REQ-026 Counters SHALL be unsigned, LEN_W/REP_W wide, never exceed latched length-1/reps-1.

Reset
REQ-027 On rst=0, state SHALL be IDLE, all counters 0, latched length/reps 0.
REQ-028 During reset: select_out=0, trigger_out=0, busy=0, done=0, err=0, m_axis_tvalid=0, s_axis_tready=0.
REQ-029 Reset mid-LOAD or mid-PLAY SHALL drop all handshakes immediately (asynchronous), no done pulse after release.
REQ-030 First start accepted on first rising edge after rst deasserts.

Configuration
REQ-031 With CHANNEL_SEQ_TIMEOUT_EN defined, a stall counter SHALL count LOAD cycles without handshake, reset on each handshake; reaching TIMEOUT SHALL go ERROR and set err=1.
REQ-032 Without CHANNEL_SEQ_TIMEOUT_EN, no stall counter exists, ERROR is unreachable, err is tied 0, LOAD waits indefinitely.

Verification
REQ-033 length=4, reps=3, start, tready=1, 4 words, ext_trigger, 12 play_beat -> ARM after 4th handshake, one trigger_out, done pulse after 12th beat, select_out 1 in ARM/PLAY, 0 in IDLE.
REQ-034 length=0, reps=5, start -> stays IDLE, busy=0, s_axis_tready=0.
REQ-035 length=8, stall m_axis_tready=0 for 3 cycles after 2 words -> still LOAD, word count 2, no data dropped; ARM after 8th handshake.
REQ-036 In PLAY after 5 beats, abort and play_beat same cycle -> IDLE next cycle, no done, select_out=0.
REQ-037 TIMEOUT=16, CHANNEL_SEQ_TIMEOUT_EN defined, length=4, s_axis_tvalid=0 after start -> ERROR after 16 LOAD cycles, err=1; start -> IDLE, err=0.
REQ-038 rst=0 asserted mid-PLAY -> all outputs 0 immediately; after release, start with length=2, reps=1 completes normally.
